freq_counter_gated: RTL and testbench

Parametrised successor to the single-digit transition-density display. Counts edges of an asynchronous input over a fixed gate window of clk cycles. Edges are counted in cascaded BCD digits, and each gate result is latched with a valid pulse and an overflow flag. The latched result is shown on a time-multiplexed 7-segment display through the existing seg7 decoder.

---
 rtl/freq_counter_gated_pkg.sv | 25 ++
 rtl/freq_counter_gated_bcd_digit.sv | 36 +++
 rtl/seg7.sv | 32 +++
 rtl/freq_counter_gated.sv | 173 +++++++++++++++++
 tb/tb_freq_counter_gated.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_counter_gated_pkg.sv
// Shared definitions for the gated frequency counter.
//   BCD_W     : width of one BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   mode_e    : edge-selection encodings (rising only / both edges)
//   bcd_step  : next value of a BCD digit given an increment request
package freq_counter_gated_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        MODE_RISE = 1'b0,
        MODE_BOTH = 1'b1
    } mode_e;

    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] d, input logic inc);
        logic [BCD_W-1:0] r;
        r = d;
        if (inc) begin
            r = (d == BCD_MAX) ? '0 : d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_counter_gated_bcd_digit.sv
// One decade of the cascaded BCD accumulator.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc_i        : add one to this digit
//   clr_i        : synchronous clear, wins over inc_i
//   digit_o      : current digit value
//   carry_o      : increment that rolls 9 -> 0, feeds the next decade
//   max_o        : digit currently holds 9
module freq_counter_gated_bcd_digit
    import freq_counter_gated_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o,
    output logic             max_o
);

    logic [BCD_W-1:0] digit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else if (clr_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= bcd_step(digit_q, inc_i);
        end
    end

    assign digit_o = digit_q;
    assign max_o   = (digit_q == BCD_MAX);
    assign carry_o = inc_i & max_o;

endmodule

// File: rtl/seg7.sv
// BCD/hex to 7-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
//   digit    : 4-bit value to display
//   segments : segment pattern
module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'h00;
        case (digit)
            4'h0: segments = 7'h3F;
            4'h1: segments = 7'h06;
            4'h2: segments = 7'h5B;
            4'h3: segments = 7'h4F;
            4'h4: segments = 7'h66;
            4'h5: segments = 7'h6D;
            4'h6: segments = 7'h7D;
            4'h7: segments = 7'h07;
            4'h8: segments = 7'h7F;
            4'h9: segments = 7'h6F;
            4'hA: segments = 7'h77;
            4'hB: segments = 7'h7C;
            4'hC: segments = 7'h39;
            4'hD: segments = 7'h5E;
            4'hE: segments = 7'h79;
            4'hF: segments = 7'h71;
            default: segments = 7'h00;
        endcase
    end

endmodule

// File: rtl/freq_counter_gated.sv
// Gated frequency counter: counts edges of an asynchronous input over a window of
// GATE_CYCLES clocks in saturating BCD, latches each window's result and scans it
// onto a multiplexed 7-segment display.
//   clk, reset_n : clock, asynchronous active-low reset
//   sig_i        : asynchronous signal under measurement
//   enable_i     : 1 runs gates; 0 holds gate/accumulator cleared, keeps result
//   mode_i       : 0 rising edges, 1 both edges; taken at gate start
//   bcd_o        : latched result, digit 0 in [3:0]
//   valid_o      : one-cycle pulse when bcd_o/overflow_o update
//   overflow_o   : last gate saturated
//   segments_o   : pattern of the selected digit
//   digit_sel_o  : one-hot digit enable, bit 0 = least significant
module freq_counter_gated
    import freq_counter_gated_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned NUM_DIGITS  = 3,
    parameter int unsigned SCAN_CYCLES = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sig_i,
    input  logic                        enable_i,
    input  logic                        mode_i,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd_o,
    output logic                        valid_o,
    output logic                        overflow_o,
    output logic [6:0]                  segments_o,
    output logic [NUM_DIGITS-1:0]       digit_sel_o
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam int unsigned AW = BCD_W * NUM_DIGITS;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;
    logic                   sig_s;
    logic                   cnt_edge;
    mode_e                  mode_q;
    logic [GW-1:0]          gcnt_q;
    logic                   gate_end;
    logic                   acc_clr;
    logic [AW-1:0]          acc;
    logic [AW-1:0]          acc_sum;
    logic [NUM_DIGITS-1:0]  dig_inc;
    logic [NUM_DIGITS-1:0]  dig_carry;
    logic [NUM_DIGITS-1:0]  dig_max;
    logic                   acc_full;
    logic                   sat_q;
    logic [AW-1:0]          bcd_q;
    logic                   valid_q;
    logic                   ovf_q;
    logic [SW-1:0]          scan_q;
    logic [NUM_DIGITS-1:0]  sel_q;
    logic [BCD_W-1:0]       sel_digit;
    logic                   unused_top_carry;

    // Input path: synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sig_d_q <= sig_s;
        end
    end

    assign sig_s    = sync_q[SYNC_STAGES-1];
    assign cnt_edge = (sig_s & ~sig_d_q) | ((mode_q == MODE_BOTH) & ~sig_s & sig_d_q);

    assign gate_end = enable_i & (gcnt_q == GATE_LAST);
    // Clearing on gate_end while the result takes acc+edge keeps every edge in exactly one gate.
    assign acc_clr  = ~enable_i | gate_end;
    assign acc_full = &dig_max;

    // Saturating cascade: the ones digit stops taking increments once all digits read 9.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign dig_inc[k] = cnt_edge & ~acc_full;
        end else begin : g_upper
            assign dig_inc[k] = dig_carry[k-1];
        end

        freq_counter_gated_bcd_digit u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .inc_i   (dig_inc[k]),
            .clr_i   (acc_clr),
            .digit_o (acc[k*BCD_W +: BCD_W]),
            .carry_o (dig_carry[k]),
            .max_o   (dig_max[k])
        );
    end

    // The top carry can never fire because increments stop at all-9s.
    assign unused_top_carry = dig_carry[NUM_DIGITS-1];

    // acc plus the edge arriving in the final gate cycle, saturating.
    always_comb begin
        acc_sum = acc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            acc_sum[k*BCD_W +: BCD_W] = bcd_step(acc[k*BCD_W +: BCD_W], dig_inc[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt_q  <= '0;
            mode_q  <= MODE_RISE;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= gate_end;
            if (!enable_i || gate_end) begin
                gcnt_q <= '0;
            end else begin
                gcnt_q <= gcnt_q + GW'(1);
            end
            if (enable_i && gcnt_q == '0) begin
                mode_q <= mode_e'(mode_i);
            end
            if (acc_clr) begin
                sat_q <= 1'b0;
            end else if (acc_full && cnt_edge) begin
                sat_q <= 1'b1;
            end
            if (gate_end) begin
                bcd_q <= acc_sum;
                ovf_q <= sat_q | (acc_full & cnt_edge);
            end
        end
    end

    // Display scan, free-running regardless of enable_i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
            sel_q  <= NUM_DIGITS'(1);
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            sel_q  <= (sel_q << 1) | (sel_q >> (NUM_DIGITS - 1));
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    always_comb begin
        sel_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_q[k]) begin
                sel_digit = bcd_q[k*BCD_W +: BCD_W];
            end
        end
    end

    seg7 u_seg7 (
        .digit    (sel_digit),
        .segments (segments_o)
    );

    assign bcd_o       = bcd_q;
    assign valid_o     = valid_q;
    assign overflow_o  = ovf_q;
    assign digit_sel_o = sel_q;

endmodule

// File: tb/tb_freq_counter_gated.sv
// Directed bench for freq_counter_gated. Instance a: 1000-cycle gate, 3 digits.
// Instance b: 1000-cycle gate, 2 digits, fast scan, 3 sync stages (saturation).
module tb_freq_counter_gated;

    logic        clk;
    logic        reset_n;
    logic        sig;
    logic        enable_a, mode_a, enable_b, mode_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic        valid_a, valid_b, ovf_a, ovf_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  sel_a;
    logic [1:0]  sel_b;

    // Stimulus generator control (written only by the main process).
    int   gen_half;
    int   gen_epoch;
    logic man_sig;

    int n_checks;
    int n_fail;

    freq_counter_gated #(
        .GATE_CYCLES (1000),
        .NUM_DIGITS  (3),
        .SCAN_CYCLES (256),
        .SYNC_STAGES (2)
    ) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .sig_i       (sig),
        .enable_i    (enable_a),
        .mode_i      (mode_a),
        .bcd_o       (bcd_a),
        .valid_o     (valid_a),
        .overflow_o  (ovf_a),
        .segments_o  (seg_a),
        .digit_sel_o (sel_a)
    );

    freq_counter_gated #(
        .GATE_CYCLES (1000),
        .NUM_DIGITS  (2),
        .SCAN_CYCLES (4),
        .SYNC_STAGES (3)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .sig_i       (sig),
        .enable_i    (enable_b),
        .mode_i      (mode_b),
        .bcd_o       (bcd_b),
        .valid_o     (valid_b),
        .overflow_o  (ovf_b),
        .segments_o  (seg_b),
        .digit_sel_o (sel_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sig either follows man_sig or toggles every gen_half cycles, 2 time units after posedge.
    initial begin
        int cnt;
        int seen;
        cnt  = 0;
        seen = 0;
        sig  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_epoch != seen) begin
                seen = gen_epoch;
                cnt  = 0;
            end
            if (gen_half == 0) begin
                sig = man_sig;
            end else begin
                if (cnt == 0) sig = ~sig;
                cnt = (cnt + 1 >= gen_half) ? 0 : cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns number of posedges until the selected valid is seen (bounded).
    task automatic wait_valid(input string tag, input bit use_b, output int cyc);
        logic v;
        v   = 1'b0;
        cyc = 0;
        while (!v && cyc < 2500) begin
            @(posedge clk);
            #1;
            cyc++;
            v = use_b ? valid_b : valid_a;
        end
        if (!v) check_eq({tag, "_timeout"}, {31'd0, v}, 32'd1);
    endtask

    task automatic wait_sel(input string tag, input bit use_b, input logic [2:0] want);
        logic [2:0] cur;
        int         n;
        n   = 0;
        cur = use_b ? {1'b0, sel_b} : sel_a;
        while (cur != want && n < 1500) begin
            @(posedge clk);
            #1;
            n++;
            cur = use_b ? {1'b0, sel_b} : sel_a;
        end
        if (cur != want) check_eq({tag, "_timeout"}, {29'd0, cur}, {29'd0, want});
    endtask

    initial begin
        int cyc;
        int nval;
        n_checks  = 0;
        n_fail    = 0;
        gen_half  = 0;
        gen_epoch = 0;
        man_sig   = 1'b0;
        enable_a  = 1'b0;
        mode_a    = 1'b0;
        enable_b  = 1'b0;
        mode_b    = 1'b0;
        reset_n   = 1'b0;

        // Reset state and idle scan.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bcd", {20'd0, bcd_a}, 32'h000);
        check_eq("rst_valid", {31'd0, valid_a}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf_a}, 32'd0);
        check_eq("rst_sel", {29'd0, sel_a}, 32'b001);
        check_eq("rst_seg", {25'd0, seg_a}, 32'h3F);
        reset_n = 1'b1;
        nval = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (valid_a) nval++;
            if (i == 255) check_eq("scan_255", {29'd0, sel_a}, 32'b001);
            if (i == 256) check_eq("scan_256", {29'd0, sel_a}, 32'b010);
            if (i == 512) check_eq("scan_512", {29'd0, sel_a}, 32'b100);
            if (i == 768) check_eq("scan_768", {29'd0, sel_a}, 32'b001);
        end
        check_eq("idle_valids", nval, 0);
        check_eq("idle_bcd", {20'd0, bcd_a}, 32'h000);

        // Rising edges, period 10 -> 100 per gate.
        enable_a  = 1'b1;
        gen_half  = 5;
        gen_epoch = gen_epoch + 1;
        wait_valid("first_gate", 0, cyc);
        check_eq("first_valid_cycles", cyc, 1000);
        wait_valid("rise_g2", 0, cyc);
        check_eq("rise_bcd", {20'd0, bcd_a}, 32'h100);
        check_eq("rise_ovf", {31'd0, ovf_a}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("valid_width", {31'd0, valid_a}, 32'd0);
        wait_valid("rise_g3", 0, cyc);
        check_eq("rise_bcd_g3", {20'd0, bcd_a}, 32'h100);
        wait_valid("rise_g4", 0, cyc);

        // Both edges, switched in the gcnt==0 cycle.
        mode_a = 1'b1;
        wait_valid("both_g1", 0, cyc);
        check_eq("both_bcd", {20'd0, bcd_a}, 32'h200);
        wait_valid("both_g2", 0, cyc);
        check_eq("both_bcd_g2", {20'd0, bcd_a}, 32'h200);
        repeat (500) @(posedge clk);
        #1;
        mode_a = 1'b0;
        wait_valid("switch_g1", 0, cyc);
        check_eq("switch_same_gate", {20'd0, bcd_a}, 32'h200);
        wait_valid("switch_g2", 0, cyc);
        check_eq("switch_next_gate", {20'd0, bcd_a}, 32'h100);

        // Asynchronous reset mid-gate.
        repeat (500) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_bcd", {20'd0, bcd_a}, 32'h000);
        check_eq("mid_rst_valid", {31'd0, valid_a}, 32'd0);
        check_eq("mid_rst_sel", {29'd0, sel_a}, 32'b001);
        check_eq("mid_rst_seg", {25'd0, seg_a}, 32'h3F);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_valid("post_rst", 0, cyc);
        check_eq("post_rst_cycles", cyc, 1000);
        check_eq("post_rst_bcd", {20'd0, bcd_a}, 32'h100);
        check_eq("post_rst_ovf", {31'd0, ovf_a}, 32'd0);

        // Gate boundary: one edge on gcnt 999, later one on gcnt 0.
        gen_half  = 0;
        man_sig   = 1'b0;
        gen_epoch = gen_epoch + 1;
        wait_valid("bnd_g0", 0, cyc);
        repeat (997) @(posedge clk);
        #1;
        man_sig = 1'b1;
        wait_valid("bnd_g1", 0, cyc);
        check_eq("bnd_last_cycle", {20'd0, bcd_a}, 32'h001);
        man_sig = 1'b0;
        repeat (998) @(posedge clk);
        #1;
        man_sig = 1'b1;
        wait_valid("bnd_g2", 0, cyc);
        check_eq("bnd_not_early", {20'd0, bcd_a}, 32'h000);
        wait_valid("bnd_g3", 0, cyc);
        check_eq("bnd_first_cycle", {20'd0, bcd_a}, 32'h001);

        // Disable: result retained, no valid.
        enable_a = 1'b0;
        nval = 0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk);
            #1;
            if (valid_a) nval++;
        end
        check_eq("dis_valids", nval, 0);
        check_eq("dis_bcd", {20'd0, bcd_a}, 32'h001);
        wait_sel("sel_a0", 0, 3'b001);
        check_eq("seg_a_digit0", {25'd0, seg_a}, 32'h06);
        wait_sel("sel_a1", 0, 3'b010);
        check_eq("seg_a_digit1", {25'd0, seg_a}, 32'h3F);

        // Saturation on the 2-digit instance: 500 edges per gate.
        enable_b  = 1'b1;
        mode_b    = 1'b1;
        gen_half  = 2;
        gen_epoch = gen_epoch + 1;
        wait_valid("sat_g1", 1, cyc);
        check_eq("sat_first_cycles", cyc, 1000);
        check_eq("sat_bcd", {24'd0, bcd_b}, 32'h99);
        check_eq("sat_ovf", {31'd0, ovf_b}, 32'd1);
        wait_valid("sat_g2", 1, cyc);
        check_eq("sat_bcd_g2", {24'd0, bcd_b}, 32'h99);
        check_eq("sat_seg", {25'd0, seg_b}, 32'h6F);
        gen_half  = 50;
        gen_epoch = gen_epoch + 1;
        wait_valid("slow_g1", 1, cyc);
        wait_valid("slow_g2", 1, cyc);
        check_eq("slow_bcd", {24'd0, bcd_b}, 32'h20);
        check_eq("slow_ovf", {31'd0, ovf_b}, 32'd0);
        wait_sel("sel_b1", 1, 3'b010);
        check_eq("seg_b_digit1", {25'd0, seg_b}, 32'h5B);
        wait_sel("sel_b0", 1, 3'b001);
        check_eq("seg_b_digit0", {25'd0, seg_b}, 32'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
